// File: rtl/hazard_ctl_if.sv
// Decode-side control bundle between the WISC pipeline and hazard_ctl.
// slave = the controller, master = the pipeline driving decode information.
interface hazard_ctl_if #(
   parameter int STALL_CNT_W = 16
);
   logic                   id_valid;
   logic [2:0]             id_rs_addr;
   logic                   id_rs_used;
   logic [2:0]             id_rt_addr;
   logic                   id_rt_used;
   logic [2:0]             id_rd_addr;
   logic                   id_rfwr;
   logic                   id_load;
   logic                   id_brj;
   logic                   id_halt;
   logic                   mem_busy;

   logic                   pc_stall;
   logic                   ifid_stall;
   logic                   idex_bubble;
   logic                   ifid_flush;
   logic                   exmem_stall;
   logic [1:0]             fwd_src1;
   logic [1:0]             fwd_src2;
   logic                   halted;
   logic [STALL_CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
             id_rd_addr, id_rfwr, id_load, id_brj, id_halt, mem_busy,
      input  pc_stall, ifid_stall, idex_bubble, ifid_flush, exmem_stall,
             fwd_src1, fwd_src2, halted, stall_count
   );

   modport slave (
      input  id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
             id_rd_addr, id_rfwr, id_load, id_brj, id_halt, mem_busy,
      output pc_stall, ifid_stall, idex_bubble, ifid_flush, exmem_stall,
             fwd_src1, fwd_src2, halted, stall_count
   );
endinterface

// File: rtl/hazard_ctl.sv
// Pipeline sequencing controller: EX/MEM write scoreboard, RAW stall, busy freeze,
// branch flush and halt drain. Define HAZARD_CTL_FWD_EN to enable EX/MEM forwarding.
module hazard_ctl #(
   parameter int STALL_CNT_W  = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   hazard_ctl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

   state_e                 state_q;
   logic [DCNT_W-1:0]      drain_cnt_q;
   logic                   halted_q;
   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic [STALL_CNT_W-1:0] stall_cnt_d;

   // Scoreboard slots; a MEM-slot result is always ready to forward, so only EX keeps load.
   logic                   ex_valid_q;
   logic [2:0]             ex_addr_q;
   logic                   ex_valid_d;
   logic                   mem_valid_q;
   logic [2:0]             mem_addr_q;
`ifdef HAZARD_CTL_FWD_EN
   logic                   ex_load_q;
`endif

   logic       busy;
   logic       hazard;
   logic       accepted;
   logic       pc_stall;
   logic       ifid_stall;
   logic       idex_bubble;
   logic       ifid_flush;
   logic       exmem_stall;

   logic [2:0] src_addr  [2];
   logic       src_used  [2];
   logic       hit_ex    [2];
   logic       hit_mem   [2];
   logic       src_stall [2];
   logic [1:0] fwd_sel   [2];

   assign src_addr[0] = bus.id_rs_addr;
   assign src_used[0] = bus.id_rs_used;
   assign src_addr[1] = bus.id_rt_addr;
   assign src_used[1] = bus.id_rt_used;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign hit_ex[gi]  = bus.id_valid && src_used[gi] && ex_valid_q
                              && (ex_addr_q == src_addr[gi]);
         assign hit_mem[gi] = bus.id_valid && src_used[gi] && mem_valid_q
                              && (mem_addr_q == src_addr[gi]);
`ifdef HAZARD_CTL_FWD_EN
         // Load-use is the only case the bypass network cannot cover.
         assign src_stall[gi] = hit_ex[gi] && ex_load_q;
         assign fwd_sel[gi]   = hit_ex[gi]  ? (ex_load_q ? 2'b00 : 2'b01) :
                                hit_mem[gi] ? 2'b10 : 2'b00;
`else
         assign src_stall[gi] = hit_ex[gi] || hit_mem[gi];
         assign fwd_sel[gi]   = 2'b00;
`endif
      end
   endgenerate

   assign hazard   = src_stall[0] || src_stall[1];
   assign busy     = bus.mem_busy && (state_q != ST_HALTED);
   assign accepted = (state_q == ST_RUN) && !hazard;

   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      exmem_stall = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (busy) begin
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               exmem_stall = 1'b1;
            end else if (hazard) begin
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               idex_bubble = 1'b1;
            end else if (bus.id_brj) begin
               ifid_flush  = 1'b1;
            end
         end
         ST_DRAIN: begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            if (busy) begin
               exmem_stall = 1'b1;
            end else begin
               idex_bubble = 1'b1;
            end
         end
         ST_HALTED: begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
         end
         default: begin
            pc_stall = 1'b0;
         end
      endcase
   end

   // HALT itself never occupies a slot: it produces no register write.
   assign ex_valid_d = bus.id_valid && bus.id_rfwr && accepted && !bus.id_halt;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == ST_RUN) && pc_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= '0;
         halted_q    <= 1'b0;
         stall_cnt_q <= '0;
         ex_valid_q  <= 1'b0;
         ex_addr_q   <= 3'd0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= 3'd0;
`ifdef HAZARD_CTL_FWD_EN
         ex_load_q   <= 1'b0;
`endif
      end else begin
         stall_cnt_q <= stall_cnt_d;

         if (!busy) begin
            mem_valid_q <= ex_valid_q;
            mem_addr_q  <= ex_addr_q;
            ex_valid_q  <= ex_valid_d;
            ex_addr_q   <= bus.id_rd_addr;
`ifdef HAZARD_CTL_FWD_EN
            ex_load_q   <= bus.id_load;
`endif
         end

         unique case (state_q)
            ST_RUN: begin
               if (!busy && accepted && bus.id_halt) begin
                  state_q     <= ST_DRAIN;
                  drain_cnt_q <= '0;
               end
            end
            ST_DRAIN: begin
               if (!busy) begin
                  if (drain_cnt_q == DRAIN_LAST) begin
                     state_q  <= ST_HALTED;
                     halted_q <= 1'b1;
                  end else begin
                     drain_cnt_q <= drain_cnt_q + 1'b1;
                  end
               end
            end
            ST_HALTED: begin
               halted_q <= 1'b1;
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   assign bus.pc_stall    = pc_stall;
   assign bus.ifid_stall  = ifid_stall;
   assign bus.idex_bubble = idex_bubble;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.exmem_stall = exmem_stall;
   assign bus.fwd_src1    = fwd_sel[0];
   assign bus.fwd_src2    = fwd_sel[1];
   assign bus.halted      = halted_q;
   assign bus.stall_count = stall_cnt_q;

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
Pipeline sequencing controller for the 5-stage WISC core. It sits beside the decode stage and tracks in-flight register writes in a 2-stage scoreboard (EX, MEM). It stalls or bubbles the decode stage on RAW hazards, freezes the pipe on memory busy, and flushes fetch on taken branches/jumps. It also sequences halt drain.
WB-stage writes are covered by the register file's internal write-before-read bypass, so WB is not tracked.

Parameters:
STALL_CNT_W, 16, width of saturating stall-cycle performance counter
DRAIN_CYCLES, 3, pipe-advance cycles after halt accept before halted asserts

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
id_valid  in  1  decode holds a real instruction
id_rs_addr  in  3  source 1 register
id_rs_used  in  1  instruction reads rs
id_rt_addr  in  3  source 2 register
id_rt_used  in  1  instruction reads rt
id_rd_addr  in  3  destination register
id_rfwr  in  1  instruction writes register file
id_load  in  1  instruction is a memory load (result available only after MEM)
id_brj  in  1  branch taken / jump from branch logic
id_halt  in  1  HALT decoded
mem_busy  in  1  data memory not ready; whole pipe must freeze
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
idex_bubble  out  1  load NOP into ID/EX
ifid_flush  out  1  replace IF/ID contents with NOP
exmem_stall  out  1  hold EX/MEM and MEM/WB registers
fwd_src1  out  2  forward select src1: 00 reg file, 01 EX result, 10 MEM result
fwd_src2  out  2  forward select src2, same encoding
halted  out  1  pipeline drained after HALT
stall_count  out  STALL_CNT_W  saturating count of cycles with pc_stall=1 in RUN

Behaviour:
- Reset (rst==0 at posedge):
  - state=RUN; EX/MEM slots invalid; drain counter=0; stall_count=0; halted=0.
  - All other outputs are combinational and evaluate to 0 when inputs are idle.
- Scoreboard slot contents: valid, addr[2:0], load.
- Hazard (no-forward build): id_valid and ((id_rs_used and rs matches a valid EX or MEM slot) or the same test for rt).
- States:
  - RUN: normal operation.
  - DRAIN: HALT accepted; counting DRAIN_CYCLES advances.
  - HALTED: terminal; left only by reset.
- Priority, highest first: mem_busy, hazard, branch, halt.
- mem_busy=1 (any state except HALTED):
  - pc_stall=ifid_stall=exmem_stall=1, idex_bubble=0, ifid_flush=0.
  - Scoreboard and drain counter frozen.
- Data stall (RUN, !mem_busy, hazard):
  - pc_stall=ifid_stall=idex_bubble=1.
  - Scoreboard advances with an invalid entry into EX.
- Advance (!mem_busy): MEM<=EX; EX<={id_valid and id_rfwr and accepted, id_rd_addr, id_load}.
  - accepted = RUN and no hazard.
  - Register 0 is tracked like any other register.
- Branch (RUN, accepted, id_brj): ifid_flush=1 for exactly that cycle; pc_stall=0.
- Halt (RUN, accepted, id_halt):
  - The HALT itself enters EX as invalid.
  - Next state DRAIN, drain counter=0.
- DRAIN:
  - pc_stall=ifid_stall=idex_bubble=1.
  - Counter increments on each non-busy cycle.
  - When the counter reaches DRAIN_CYCLES-1 on a non-busy cycle, go to HALTED.
- HALTED: halted=1, pc_stall=ifid_stall=idex_bubble=1, exmem_stall=0; inputs ignored.
- stall_count:
  - Increments when state==RUN and pc_stall==1.
  - Holds at 2^STALL_CNT_W-1.
- Hazard with id_brj: the stall wins and no flush occurs; the branch re-evaluates next cycle.
- Reset asserted mid-DRAIN or mid-stall returns to RUN the same edge.

Optional Feature:
Macro HAZARD_CTL_FWD_EN.
- Defined:
  - A source matching a valid EX slot with load=0 gives fwd=01, no stall.
  - A source matching a valid MEM slot gives fwd=10.
  - EX match beats MEM match.
  - Only an EX-slot load match stalls (load-use, 1 bubble).
- Undefined: fwd_src1/fwd_src2 are tied 00, and any EX/MEM match stalls.

Test Plan:
1. Reset with rst=0 for 2 cycles, all inputs 0 -> every output 0, stall_count=0, halted=0.
2. No-FWD build: ADD r3 (rfwr, rd=3), then next cycle a decode reading rs=3 -> 2 stall cycles (pc_stall/idex_bubble=1), stall_count=2, issue on third cycle.
3. FWD build: ADD r3 followed by a use of r3 -> fwd_src1=01, no stall. LD r3 followed by a use of r3 -> 1 bubble, then fwd_src1=10.
4. id_brj=1 with no hazard -> ifid_flush=1 for exactly 1 cycle. The same with a simultaneous hazard -> no flush that cycle, flush on the following cycle.
5. mem_busy held 4 cycles during a data stall -> exmem_stall=1 and idex_bubble=0 for those 4 cycles, scoreboard unchanged, and the stall resumes afterwards.
6. HALT accepted with mem_busy pulsed 2 cycles during DRAIN -> halted asserts 3+2=5 cycles after accept and stays 1 until rst=0.
